// File: rtl/memory_ctrl.sv
// Single-port word memory with byte-enabled writes, a post-reset zeroing sweep,
// and an optional output register on the read path (OutReg = 0 or 1).
module memory_ctrl #(
    parameter int AddrSize = 8,
    parameter int DataSize = 32,
    parameter int OutReg   = 0
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Valid,
    output logic                  Ready,
    input  logic                  R_W,
    input  logic [AddrSize-1:0]   Addr,
    input  logic [DataSize-1:0]   Din,
    input  logic [DataSize/8-1:0] ByteEn,
    output logic [DataSize-1:0]   Dout,
    output logic                  DoutValid,
    output logic                  InitDone
);

    localparam int Depth = 2 ** AddrSize;
    localparam int Bytes = DataSize / 8;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [AddrSize-1:0] sweep;
    logic [AddrSize-1:0] sweep_next;
    logic [DataSize-1:0] mem [Depth];

    logic                accept;
    logic                wr_accept;
    logic                rd_accept;
    logic                rd_valid;
    logic [DataSize-1:0] rd_data;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= INIT;
            sweep <= '0;
        end else begin
            state <= state_next;
            sweep <= sweep_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        sweep_next = sweep;
        Ready      = 1'b0;
        InitDone   = 1'b0;
        case (state)
            INIT: begin
                // The last word is cleared on the same cycle we leave INIT; the counter then parks.
                if (&sweep) state_next = RUN;
                else        sweep_next = sweep + AddrSize'(1);
            end
            RUN: begin
                Ready    = !Reset;
                InitDone = !Reset;
            end
        endcase
    end

    assign accept    = Valid && Ready;
    assign wr_accept = accept && R_W;
    assign rd_accept = accept && !R_W;

    // NOTE: the array has no reset branch; the INIT sweep zeroes it, keeping it mappable to RAM.
    always_ff @(posedge Clk) begin
        if (state == INIT) begin
            mem[sweep] <= '0;
        end else if (wr_accept) begin
            for (int b = 0; b < Bytes; b++) begin
                if (ByteEn[b]) mem[Addr][8*b +: 8] <= Din[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_accept;
            if (rd_accept) rd_data <= mem[Addr];
        end
    end

    generate
        if (OutReg != 0) begin : g_out_reg
            logic                dout_valid_q;
            logic [DataSize-1:0] dout_q;

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    dout_valid_q <= 1'b0;
                    dout_q       <= '0;
                end else begin
                    dout_valid_q <= rd_valid;
                    if (rd_valid) dout_q <= rd_data;
                end
            end

            assign Dout      = dout_q;
            assign DoutValid = dout_valid_q;
        end else begin : g_no_out_reg
            assign Dout      = rd_data;
            assign DoutValid = rd_valid;
        end
    endgenerate

endmodule
